// File: rtl/md_sequencer.sv
// Sequencer for the iterative multiply/divide units: start pulses, fixed-latency
// countdown, HI/LO source select and write strobe, plus divide-by-zero reporting.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mult_req,
  input  logic        div_req,
  input  logic        flush,
  input  logic [31:0] b_operand,
  output logic        mult_start,
  output logic        div_start,
  output logic        md_sel,
  output logic        hilo_write,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  typedef enum logic [2:0] {StIdle, StRunMult, StRunDiv, StWrite, StDiv0} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_mult_start, r_div_start, r_md_sel, r_hilo_write, r_busy, r_done, r_div0;
  logic             w_md_sel_d;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_md_sel_d = r_md_sel;
    unique case (r_state)
      StIdle: begin
        // flush outranks any same-cycle request; mult outranks div
        if (!flush) begin
          if (mult_req) begin
            w_state_d  = StRunMult;
            w_cnt_d    = CNT_W'(MULT_CYCLES - 1);
            w_md_sel_d = 1'b0;
          end else if (div_req) begin
            if (b_operand != 32'd0) begin
              w_state_d  = StRunDiv;
              w_cnt_d    = CNT_W'(DIV_CYCLES - 1);
              w_md_sel_d = 1'b1;
            end else begin
              w_state_d = StDiv0;
            end
          end
        end
      end
      StRunMult, StRunDiv: begin
        if (flush) begin
          w_state_d = StIdle;
        end else if (r_cnt == '0) begin
          w_state_d = StWrite;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StWrite, StDiv0: w_state_d = StIdle;
      default:         w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_md_sel     <= 1'b0;
      r_hilo_write <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_div0       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      // Outputs are registered decodes of the state being entered
      r_mult_start <= (r_state == StIdle) && (w_state_d == StRunMult);
      r_div_start  <= (r_state == StIdle) && (w_state_d == StRunDiv);
      r_md_sel     <= w_md_sel_d;
      r_hilo_write <= (w_state_d == StWrite);
      r_busy       <= (w_state_d != StIdle);
      r_done       <= (w_state_d == StWrite);
      r_div0       <= (w_state_d == StDiv0);
    end
  end

  assign mult_start = r_mult_start;
  assign div_start  = r_div_start;
  assign md_sel     = r_md_sel;
  assign hilo_write = r_hilo_write;
  assign busy       = r_busy;
  assign done       = r_done;
  assign div0       = r_div0;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus random traffic,
// scored against an operation-schedule model (accept cycle, write cycle, free cycle).
module tb_md_sequencer;

  localparam int MC = 32;
  localparam int DC = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mult_req = 1'b0;
  logic        div_req = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] b_operand = 32'd0;
  logic        mult_start, div_start, md_sel, hilo_write, busy, done, div0;

  always #5 clock = ~clock;

  md_sequencer #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC),
    .CNT_W      (6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mult_req  (mult_req),
    .div_req   (div_req),
    .flush     (flush),
    .b_operand (b_operand),
    .mult_start(mult_start),
    .div_start (div_start),
    .md_sel    (md_sel),
    .hilo_write(hilo_write),
    .busy      (busy),
    .done      (done),
    .div0      (div0)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Model: the current operation is described by when it was accepted, its kind
  // (0 none, 1 mult, 2 div, 3 div-by-zero), the cycle of its write (-1 none) and
  // the first cycle a new request can be accepted.
  int   m_acc   = -10;
  int   m_kind  = 0;
  int   m_write = -1;
  int   m_free  = 0;
  logic m_sel   = 1'b0;

  logic [6:0] obs;
  assign obs = {mult_start, div_start, md_sel, hilo_write, busy, done, div0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %h want %h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [6:0] exp_outs(input int c);
    logic first, wr, bz;
    first = (c == m_acc + 1);
    wr    = (c == m_write);
    bz    = (c > m_acc) && (c < m_free);
    return {m_kind == 1 && first, m_kind == 2 && first, m_sel, wr, bz, wr, m_kind == 3 && first};
  endfunction

  task automatic model_reset();
    m_acc   = -10;
    m_kind  = 0;
    m_write = -1;
    m_free  = cyc;
    m_sel   = 1'b0;
  endtask

  task automatic model_update(input logic mr, input logic dr, input logic fl,
                              input logic [31:0] b);
    if (cyc >= m_free) begin
      if (!fl && (mr || dr)) begin
        m_acc = cyc;
        if (mr) begin
          m_kind = 1; m_write = cyc + MC + 1; m_free = cyc + MC + 2; m_sel = 1'b0;
        end else if (b != 32'd0) begin
          m_kind = 2; m_write = cyc + DC + 1; m_free = cyc + DC + 2; m_sel = 1'b1;
        end else begin
          m_kind = 3; m_write = -1; m_free = cyc + 2;
        end
      end
    end else if (fl && (m_kind == 1 || m_kind == 2) && m_write >= 0 && cyc < m_write) begin
      m_free  = cyc + 1;
      m_write = -1;
    end
  endtask

  // One cycle: check this cycle's outputs, then drive and model this cycle's inputs.
  task automatic step(input logic mr, input logic dr, input logic fl,
                      input logic [31:0] b, input logic rn);
    @(negedge clock);
    cyc++;
    check("outs", {25'd0, obs}, {25'd0, exp_outs(cyc)});
    mult_req  = mr;
    div_req   = dr;
    flush     = fl;
    b_operand = b;
    reset     = rn;
    if (!rn) model_reset();
    else     model_update(mr, dr, fl, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    // Reset held with a pending mult_req
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(3);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Multiply, then back-to-back request right after WRITE
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(33);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(36);

    // Divide with nonzero divisor
    step(1'b0, 1'b1, 1'b0, 32'd7, 1'b1);
    idle(36);

    // Divide by zero
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    idle(3);

    // Simultaneous requests: multiplier wins
    step(1'b1, 1'b1, 1'b0, 32'd5, 1'b1);
    idle(36);

    // div_req during a multiply is ignored
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(9);
    step(1'b0, 1'b1, 1'b0, 32'd9, 1'b1);
    idle(30);

    // Flush mid-divide
    step(1'b0, 1'b1, 1'b0, 32'd3, 1'b1);
    idle(14);
    step(1'b0, 1'b0, 1'b1, 32'd0, 1'b1);
    idle(25);

    // Flush suppresses a same-cycle request in IDLE
    step(1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
    idle(3);

    // Asynchronous reset mid multiply
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(10);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("async_rst", {25'd0, obs}, 32'd0);
    model_reset();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        mr, dr, fl;
      logic [31:0] b;
      mr = ($urandom_range(0, 19) == 0);
      dr = ($urandom_range(0, 14) == 0);
      fl = ($urandom_range(0, 39) == 0);
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(mr, dr, fl, b, 1'b1);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequences the iterative multiply and divide units and their shared HI/LO write path.
- CONTROL issues a single-cycle mult_req or div_req.
- This block:
  - pulses the unit's start line (MULTcontrol / DIVcontrol);
  - counts the unit's fixed latency;
  - selects the HI/LO source mux (MDcontrol);
  - strobes HILOWrite;
  - reports busy, done and divide-by-zero back to CONTROL.

Parameters:
MULT_CYCLES, 32, cycles the multiplier needs after its start pulse before hi/lo outputs are valid; must be ≥1.
DIV_CYCLES, 32, cycles the divider needs after its start pulse before hi/lo outputs are valid; must be ≥1.
CNT_W, 6, latency counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
mult_req  in  1  one-cycle request to start MULT (from CONTROL).
div_req  in  1  one-cycle request to start DIV (from CONTROL).
flush  in  1  synchronous abort of any operation in flight.
b_operand  in  32  divisor (B register output), sampled in the div_req cycle.
mult_start  out  1  MULTcontrol: one-cycle start pulse to the multiplier.
div_start  out  1  DIVcontrol: one-cycle start pulse to the divider.
md_sel  out  1  MDcontrol: 0 = multiplier hi/lo, 1 = divider hi/lo.
hilo_write  out  1  HILOWrite strobe for the HI and LO registers.
busy  out  1  operation in flight; CONTROL stalls while high.
done  out  1  one-cycle completion pulse, coincident with hilo_write.
div0  out  1  one-cycle divide-by-zero exception pulse.

Behaviour:
- All outputs registered; Moore-style decode of state.
- States: IDLE, RUN_MULT, RUN_DIV, WRITE, DIV0.
- Counter cnt is CNT_W bits wide.
- Reset (reset=0, any time, asynchronous):
  - state=IDLE, cnt=0;
  - mult_start, div_start, md_sel, hilo_write, busy, done, div0 all 0.
- Operation in flight at reset is discarded; no HILO write.
- IDLE:
  - mult_req=1 → RUN_MULT; cnt=MULT_CYCLES-1; md_sel=0.
  - div_req=1 and b_operand≠0 → RUN_DIV; cnt=DIV_CYCLES-1; md_sel=1.
  - div_req=1 and b_operand=0 → DIV0.
  - mult_req and div_req in the same cycle: mult wins, div_req is dropped (protocol violation, no error flag).
- RUN_x:
  - Start pulse (mult_start or div_start) is high only in the first RUN cycle.
  - busy=1.
  - cnt decrements by 1 each cycle; cnt=0 → WRITE next edge.
- WRITE: hilo_write=1, done=1, busy=1 for exactly one cycle, then IDLE.
- md_sel holds its value from operation entry through WRITE and remains stable in IDLE until the next request.
- DIV0:
  - div0=1, busy=1 for one cycle, then IDLE.
  - No div_start, no hilo_write, no done.
- Latency, with the request sampled at edge 0:
  - first RUN cycle follows edge 0;
  - WRITE is cycle N+1 after the request cycle (N = MULT_CYCLES or DIV_CYCLES);
  - next request is accepted in the cycle after WRITE.
  - DIV0 is the cycle after the request.
- Requests while busy=1 (RUN, WRITE, DIV0) are ignored; they are neither queued nor flagged.
- flush=1:
  - In RUN_x → IDLE next edge; no hilo_write, no done.
  - In WRITE or DIV0: the current pulse completes, then IDLE (same as normal).
  - In IDLE: any same-cycle request is suppressed.
  - flush has priority over requests; reset has priority over flush.
- cnt never wraps: it is only decremented in RUN_x with cnt>0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with mult_req=1 → all outputs 0, state IDLE; after release, IDLE with busy=0.
- Multiply: mult_req pulse at cycle 0 (defaults) →
  - mult_start=1 in cycle 1 only;
  - busy=1 in cycles 1–33;
  - hilo_write=done=1 in cycle 33 only, md_sel=0;
  - a new mult_req in cycle 34 is accepted.
- Divide: div_req with b_operand=7 →
  - div_start=1 in cycle 1;
  - md_sel=1 from cycle 1;
  - hilo_write in cycle 33;
  - div0 stays 0.
- Divide by zero: div_req with b_operand=0 →
  - div0=1 in cycle 1 only;
  - div_start, hilo_write and done stay 0;
  - busy=0 in cycle 2.
- Conflicts: mult_req+div_req in the same cycle → multiplier path only. A div_req in cycle 10 of a multiply → ignored; no second write.
- Abort: flush in cycle 15 of a divide → busy=0 from cycle 16; no hilo_write ever. Asynchronous reset=0 mid-RUN_MULT → outputs 0 immediately, without waiting for a clock edge.
